id_pipe_stage: RTL
==================

// Module: id_pipe_stage
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
//  - Holds the IF/ID pipeline register.
//  - Contains the 32x32 register file and the main control decoder.
//  - Resolves beq/j in ID and returns branch_address, jump_address, branch_taken, jump and en to fetch.
//  - Detects load-use hazards and inserts bubbles toward EX.
// PARAMETERS
//  PC_W    10  PC / instruction-memory byte-address width
//  DATA_W  32  datapath and instruction width
//  NREG    32  register count; index width is 5
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  pc_plus4_in     in   10      PC+4 from fetch
//  instr_in        in   32      instruction from fetch
//  mem_read_ex     in   1       instruction in EX is a load
//  rt_ex           in   5       destination of that load
//  reg_write_wb    in   1       WB write enable
//  write_reg_wb    in   5       WB destination register
//  write_data_wb   in   32      WB write data
//  if_en           out  1       fetch PC enable; 0 = stall
//  branch_address  out  10      pc_plus4_id + (sign_ext(imm)<<2), truncated to 10 bits
//  jump_address    out  10      {instr_id[7:0],2'b00}
//  branch_taken    out  1       beq taken
//  jump            out  1       j decoded
//  reg1_data       out  32      rs read data
//  reg2_data       out  32      rt read data
//  imm_ext         out  32      sign-extended instr_id[15:0]
//  rs, rt, rd      out  5 each  register fields of instr_id
//  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write  out  1 each  controls to EX
//  alu_op          out  2       00 add, 01 sub, 10 R-type funct
// BEHAVIOUR
//  IF/ID register (pc_plus4_id, instr_id)
//  - Reset: both 0; 0 is a NOP, so every control output is 0.
//  - Stall: hold both registers.
//  - Flush (branch_taken|jump, no stall): load 0.
//  - Otherwise: capture the inputs. One-cycle latency from fetch.
//  Hazard (combinational)
//  - stall = mem_read_ex & rt_ex!=0 & (rt_ex==rs | rt_ex==rt).
//  - During stall: if_en=0; every control output, branch_taken and jump forced to 0 (bubble).
//  - Stall has priority over flush.
//  - Otherwise if_en=1.
//  Decode (opcode; controls listed are 1, all others 0)
//  - 0x00 R-type: reg_dst, reg_write; alu_op=10.
//  - 0x23 lw: alu_src, mem_to_reg, reg_write, mem_read; alu_op=00.
//  - 0x2B sw: alu_src, mem_write; alu_op=00.
//  - 0x08 addi: alu_src, reg_write; alu_op=00.
//  - 0x04 beq: alu_op=01; branch_taken = reg1_data==reg2_data.
//  - 0x02 j: jump=1.
//  - Any other opcode: all controls 0.
//  Register file
//  - Write on posedge when reg_write_wb & write_reg_wb!=0.
//  - $0 always reads 0.
//  - Reset clears all registers to 0.
//  - Read ports combinational. Same-cycle WB write to a read register bypasses: write_data_wb is returned, never $0.
//  Arithmetic
//  - Branch-address add is modulo 2^10; wrap-around is silent.
//  - Reset asserted mid-stall or mid-flush: IF/ID=0 next cycle; stall state is not retained.
// CONFIGURATION
//  - ID_BRANCH_FWD_EN defined: adds inputs reg_write_mem(1), write_reg_mem(5), alu_result_mem(32).
//    - The beq comparator takes alu_result_mem for rs/rt when reg_write_mem & write_reg_mem!=0 & the register matches.
//    - MEM forwarding has priority over the WB bypass.
//    - reg1_data/reg2_data to EX are unaffected.
//  - ID_BRANCH_FWD_EN undefined: ports absent; the comparator uses register-file outputs only (WB bypass still applies).
// STRUCTURE
//  - mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J), ALU_OP_* encodings, NOP_INSTR.
//  - Sub-module reg_file: 2 read ports, 1 write port, bypass, reset clear.
//  - IF/ID register, hazard logic and decoder stay in id_pipe_stage.
// TESTING
//  1. Reset, then WB write $8=0x1234; present instr 0x01084820 (add $9,$8,$8) -> reg1_data=reg2_data=0x1234, reg_dst=1, alu_op=10.
//  2. mem_read_ex=1, rt_ex=8, instr_id add $9,$8,$8 -> if_en=0, all controls 0, instr_id held; next cycle with mem_read_ex=0 -> if_en=1.
//  3. $1=$2=5, pc_plus4_id=0x010, instr beq $1,$2,3 (0x10220003) -> branch_taken=1, branch_address=0x01C; next cycle instr_id=0.
//  4. instr 0x08000010 (j) -> jump=1, jump_address=0x040; next cycle instr_id=0. $1!=$2 beq -> branch_taken=0, no flush.
//  5. WB write $0=0xFFFF_FFFF -> $0 reads 0. Same-cycle WB write $5=7 while reading $5 -> reg1_data=7.
//  6. ID_BRANCH_FWD_EN: reg_write_mem=1, write_reg_mem=1, alu_result_mem=9, $2=9, beq $1,$2 -> branch_taken=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, ALU-op encodings,
// the NOP word and the control bundle produced by the main decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       is_beq;
        logic       is_j;
    } ctrl_t;

    // The all-zero word shares opcode 0 with R-type, so it is caught first
    // to keep a flushed/reset slot completely inert.
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        if (instr != NOP_INSTR) begin
            case (instr[31:26])
                OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_FUNCT; end
                OP_LW:    begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                                c.mem_read = 1'b1; c.alu_op = ALU_OP_ADD; end
                OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_OP_ADD; end
                OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_ADD; end
                OP_BEQ:   begin c.alu_op = ALU_OP_SUB; c.is_beq = 1'b1; end
                OP_J:     c.is_j = 1'b1;
                default:  c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/id_pipe_stage_if.sv
// Bus between fetch / EX / WB and the decode stage.
// ID_BRANCH_FWD_EN adds the MEM-stage forwarding inputs for the beq comparator.
interface id_pipe_stage_if #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32,
    parameter int RW     = 5
);
    logic [PC_W-1:0]   pc_plus4_in;
    logic [DATA_W-1:0] instr_in;
    logic              mem_read_ex;
    logic [RW-1:0]     rt_ex;
    logic              reg_write_wb;
    logic [RW-1:0]     write_reg_wb;
    logic [DATA_W-1:0] write_data_wb;
`ifdef ID_BRANCH_FWD_EN
    logic              reg_write_mem;
    logic [RW-1:0]     write_reg_mem;
    logic [DATA_W-1:0] alu_result_mem;
`endif
    logic              if_en;
    logic [PC_W-1:0]   branch_address;
    logic [PC_W-1:0]   jump_address;
    logic              branch_taken;
    logic              jump;
    logic [DATA_W-1:0] reg1_data;
    logic [DATA_W-1:0] reg2_data;
    logic [DATA_W-1:0] imm_ext;
    logic [RW-1:0]     rs, rt, rd;
    logic              reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0]        alu_op;

    modport slave (
        input  pc_plus4_in, instr_in, mem_read_ex, rt_ex,
               reg_write_wb, write_reg_wb, write_data_wb,
`ifdef ID_BRANCH_FWD_EN
        input  reg_write_mem, write_reg_mem, alu_result_mem,
`endif
        output if_en, branch_address, jump_address, branch_taken, jump,
               reg1_data, reg2_data, imm_ext, rs, rt, rd,
               reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op
    );

    modport master (
        output pc_plus4_in, instr_in, mem_read_ex, rt_ex,
               reg_write_wb, write_reg_wb, write_data_wb,
`ifdef ID_BRANCH_FWD_EN
        output reg_write_mem, write_reg_mem, alu_result_mem,
`endif
        input  if_en, branch_address, jump_address, branch_taken, jump,
               reg1_data, reg2_data, imm_ext, rs, rt, rd,
               reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op
    );
endinterface

// File: rtl/id_pipe_stage_reg_file.sv
// 2R/1W register file; $0 hardwired to zero, same-cycle WB write bypassed
// onto the read ports so decode never sees a stale value.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RW-1:0]     ra1,
    input  logic [RW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [RW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);
    logic [NREG-1:0][DATA_W-1:0] regs;

    // Storage: synchronous clear, writes to $0 dropped
    always_ff @(posedge clk) begin
        if (reset)
            regs <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
    end

    // Read ports with WB bypass; $0 wins over everything
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (ra1 == '0)          rd1 = '0;
        else if (we && wa == ra1) rd1 = wd;
        if (ra2 == '0)          rd2 = '0;
        else if (we && wa == ra2) rd2 = wd;
    end
endmodule

// File: rtl/id_pipe_stage.sv
// MIPS decode stage: IF/ID register, register file, main decoder, beq/j
// resolution and load-use stall.
// Optional macro ID_BRANCH_FWD_EN: MEM-stage forwarding into the beq comparator.
module id_pipe_stage
    import mips_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    localparam int RW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    id_pipe_stage_if.slave bus
);
    logic [PC_W-1:0]   pc_plus4_id;
    logic [DATA_W-1:0] instr_id;
    logic [RW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] imm_ext, rf_rd1, rf_rd2, cmp_a, cmp_b;
    logic              stall;
    ctrl_t             ctrl;

    assign rs      = instr_id[25:21];
    assign rt      = instr_id[20:16];
    assign rd      = instr_id[15:11];
    assign imm_ext = {{(DATA_W-16){instr_id[15]}}, instr_id[15:0]};

    assign stall = bus.mem_read_ex && (bus.rt_ex != '0) &&
                   ((bus.rt_ex == rs) || (bus.rt_ex == rt));

    reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (bus.reg_write_wb),
        .wa    (bus.write_reg_wb),
        .wd    (bus.write_data_wb)
    );

`ifdef ID_BRANCH_FWD_EN
    // Comparator operands: MEM result takes priority over the (bypassed) RF read
    always_comb begin
        cmp_a = rf_rd1;
        cmp_b = rf_rd2;
        if (bus.reg_write_mem && bus.write_reg_mem != '0 && bus.write_reg_mem == rs)
            cmp_a = bus.alu_result_mem;
        if (bus.reg_write_mem && bus.write_reg_mem != '0 && bus.write_reg_mem == rt)
            cmp_b = bus.alu_result_mem;
    end
`else
    assign cmp_a = rf_rd1;
    assign cmp_b = rf_rd2;
`endif

    // Decode, then squash to a bubble while the load-use stall is active
    always_comb begin
        ctrl = decode(instr_id);
        if (stall) ctrl = '0;
    end

    assign bus.if_en          = ~stall;
    assign bus.branch_taken   = ctrl.is_beq && (cmp_a == cmp_b);
    assign bus.jump           = ctrl.is_j;
    assign bus.branch_address = pc_plus4_id + {imm_ext[PC_W-3:0], 2'b00};
    assign bus.jump_address   = {instr_id[PC_W-3:0], 2'b00};
    assign bus.reg1_data      = rf_rd1;
    assign bus.reg2_data      = rf_rd2;
    assign bus.imm_ext        = imm_ext;
    assign bus.rs             = rs;
    assign bus.rt             = rt;
    assign bus.rd             = rd;
    assign bus.reg_dst        = ctrl.reg_dst;
    assign bus.alu_src        = ctrl.alu_src;
    assign bus.mem_to_reg     = ctrl.mem_to_reg;
    assign bus.reg_write      = ctrl.reg_write;
    assign bus.mem_read       = ctrl.mem_read;
    assign bus.mem_write      = ctrl.mem_write;
    assign bus.alu_op         = ctrl.alu_op;

    // IF/ID register: hold on stall, squash on taken branch/jump, else capture
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_plus4_id <= '0;
            instr_id    <= NOP_INSTR;
        end else if (stall) begin
            pc_plus4_id <= pc_plus4_id;
            instr_id    <= instr_id;
        end else if (bus.branch_taken || bus.jump) begin
            pc_plus4_id <= '0;
            instr_id    <= NOP_INSTR;
        end else begin
            pc_plus4_id <= bus.pc_plus4_in;
            instr_id    <= bus.instr_in;
        end
    end
endmodule
